mem_req_master: RTL
===================

// Module: mem_req_master
// PURPOSE
//  Initiator for the single-port memory interface: the command-issuing end of the link the memory
//  block responds to. Accepts read/write commands on a valid/ready port and drives one memory access
//  per command. Captures read data after a fixed latency and returns it in order through a response FIFO.
//  Sits between stimulus or CPU-side logic and the memory block; replaces hand-driven access sequences.
// PARAMETERS
//  ADDR_W     8   memory address width
//  DATA_W     8   memory data width
//  RD_LAT     1   cycles from mem_en (read) to valid mem_rdata; range 1..4
//  RSP_DEPTH  4   response FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1        clock; all logic on rising edge
//  rst        in   1        reset; synchronous, active-low
//  cmd_valid  in   1        command valid
//  cmd_ready  out  1        command accepted when cmd_valid & cmd_ready
//  cmd_wr     in   1        1 = write, 0 = read
//  cmd_addr   in   ADDR_W   command address
//  cmd_wdata  in   DATA_W   write data (ignored for reads)
//  rsp_valid  out  1        read response available
//  rsp_ready  in   1        response consumed when rsp_valid & rsp_ready
//  rsp_addr   out  ADDR_W   address of the read being returned
//  rsp_rdata  out  DATA_W   read data
//  mem_en     out  1        memory access strobe, one cycle per command
//  mem_we     out  1        write enable, qualified by mem_en
//  mem_addr   out  ADDR_W   memory address
//  mem_wdata  out  DATA_W   memory write data
//  mem_rdata  in   DATA_W   memory read data
//  wr_count   out  16       completed writes, wraps at 2^16
//  rd_count   out  16       reads pushed to FIFO, wraps at 2^16
// BEHAVIOUR
//  Reset (rst==0 at edge): state IDLE; FIFO emptied; counters 0.
//   All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_addr, rsp_rdata.
//   cmd_ready goes 1 on the first cycle after reset releases.
//  FSM states and transitions:
//   IDLE  -> ISSUE on handshake; latch cmd_wr, cmd_addr, cmd_wdata.
//   ISSUE -> IDLE if write; wr_count++.
//   ISSUE -> WAIT if read.
//   WAIT  -> IDLE after RD_LAT cycles; push {addr, mem_rdata}; rd_count++.
//  Outputs by state:
//   ISSUE: mem_en=1, mem_we=cmd_wr, mem_addr/mem_wdata = latched values, for exactly one cycle.
//   Outside ISSUE: mem_en=0, mem_we=0; mem_addr/mem_wdata hold their last values.
//  Timing, handshake in cycle T:
//   mem_en is high in T+1.
//   mem_rdata is sampled at the end of cycle T+1+RD_LAT.
//   rsp_valid is high no earlier than T+2+RD_LAT.
//   Next cmd_ready: T+2 for a write, T+2+RD_LAT for a read.
//  cmd_ready = (state==IDLE) && !fifo_full. At most one read is in flight, so the WAIT push never overflows.
//  cmd_valid/cmd_* may change freely while cmd_ready==0; they are ignored.
//  FIFO is first-word-fall-through:
//   rsp_valid = !empty; rsp_addr/rsp_rdata show the head entry.
//   Head is stable while rsp_valid && !rsp_ready.
//  Simultaneous push and pop: count unchanged, both take effect. Pop from a full FIFO reopens cmd_ready next cycle.
//  Responses are returned in command order; writes produce no response.
//  Reset mid-read: the in-flight read is discarded, nothing is pushed, rd_count is not incremented.
//  Pointers wrap modulo RSP_DEPTH; count width is $clog2(RSP_DEPTH)+1.
// STRUCTURE
//  Package mem_req_pkg:
//   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} mreq_state_e.
//   rsp_entry_t struct {addr, rdata}, parameterised via package defaults ADDR_W/DATA_W.
//  Sub-module mem_rsp_fifo (DEPTH, WIDTH):
//   Sync FWFT FIFO with push, pop, full, empty, count, same clk/rst.
//  Top holds the FSM, RD_LAT wait counter and statistics counters.
// TESTING
//  1 Write 0xA5 @0x10: mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5 for exactly one cycle;
//    wr_count=1; no rsp_valid.
//  2 Read @0x10 after test 1: rsp_valid at T+3 (RD_LAT=1), rsp_addr=0x10, rsp_rdata=0xA5;
//    mem_we=0 in the issue cycle.
//  3 rsp_ready=0; read @0..@3 holding 0x00,0x11,0x22,0x33:
//    after 4 reads cmd_ready=0; rsp_valid held with head 0x00.
//    Raise rsp_ready: data 0x00,0x11,0x22,0x33 in order; cmd_ready returns after the first pop.
//  4 Back-to-back cmd_valid=1 with 8 alternating writes and reads: no command lost or duplicated.
//    mem_en pulses exactly 8 times; wr_count=4, rd_count=4.
//  5 Assert rst=0 in the cycle after a read issue:
//    next cycle all outputs 0, FIFO empty, rd_count=0; no late response after release.
//  6 RD_LAT=3 build, read @0x20 holding 0x5C:
//    mem_rdata sampled 3 cycles after mem_en; rsp_valid at T+5 with 0x5C.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types for the memory request initiator: FSM states, response entry layout and the
// read-latency counter sizing.
package mem_req_pkg;

   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned RD_LAT_MAX = 4;
   localparam int unsigned LAT_CNT_W  = $clog2(RD_LAT_MAX);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } mreq_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] rdata;
   } rsp_entry_t;

   // Terminal value of the WAIT-state counter for a given read latency.
   function automatic logic [LAT_CNT_W-1:0] lat_last(input int unsigned rd_lat);
      return LAT_CNT_W'(rd_lat - 1);
   endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding read responses; the head entry is visible on
// rdata whenever empty is low.
module mem_rsp_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage is cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (do_pop && !do_push) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/mem_req_master.sv
// Command-issuing end of the single-port memory link: one memory access per accepted command,
// read data captured after RD_LAT cycles and returned in order through a response FIFO.
module mem_req_master
   import mem_req_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       wr_count,
   output logic [15:0]       rd_count
);

   localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;
   localparam logic [LAT_CNT_W-1:0] LatLast = lat_last(RD_LAT);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] rdata;
   } entry_t;

   mreq_state_e          state_q, state_d;
   logic [LAT_CNT_W-1:0] lat_q, lat_d;
   logic                 wr_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [15:0]          wr_cnt_q;
   logic [15:0]          rd_cnt_q;
   logic                 rdy_en_q;

   logic                 cmd_fire;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;
   entry_t               push_entry;
   entry_t               head_entry;

   // rdy_en_q keeps cmd_ready low while reset is held and for the release edge itself.
   assign cmd_ready = rdy_en_q && (state_q == IDLE) && !fifo_full;
   assign cmd_fire  = cmd_valid && cmd_ready;

   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      fifo_push = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (wr_q) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
               lat_d   = '0;
            end
         end
         WAIT: begin
            if (lat_q == LatLast) begin
               fifo_push = 1'b1;
               state_d   = IDLE;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         lat_q    <= '0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         rdy_en_q <= 1'b1;
         if (cmd_fire) begin
            wr_q    <= cmd_wr;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
         end
         if ((state_q == ISSUE) && wr_q) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
         end
         if (fifo_push) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
         end
      end
   end

   assign mem_en    = (state_q == ISSUE);
   assign mem_we    = mem_en && wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign wr_count  = wr_cnt_q;
   assign rd_count  = rd_cnt_q;

   assign push_entry = '{addr: addr_q, rdata: mem_rdata};
   assign fifo_pop   = rsp_valid && rsp_ready;
   assign rsp_valid  = !fifo_empty;
   assign rsp_addr   = head_entry.addr;
   assign rsp_rdata  = head_entry.rdata;

   mem_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (push_entry),
      .pop   (fifo_pop),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Only one read is ever in flight and cmd_ready needs a free slot, so a push always fits.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      fifo_push |-> (fifo_count < CNT_W'(RSP_DEPTH)));

endmodule
